// File: rtl/toycpu_ctrl.sv
// toycpu_ctrl -- multi-cycle control unit for the toycpu core.
//
// Fetches 16-bit instructions over a req/ack instruction-memory port,
// decodes them and sequences the register file and the ADD/MV ALU.
// Owns the program counter and resolves the flag-conditional jumps.
//
// Instruction format: ir[15:12] opcode, ir[11:8] rd, ir[7:4] rs,
// ir[3:0] rt, imm8 = ir[7:0], jump target = ir[PC_W-1:0].
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   imem_req     instruction fetch request (held until imem_ack)
//   imem_addr    fetch address (= PC)
//   imem_ack     fetch complete, imem_rdata valid this cycle
//   imem_rdata   instruction word
//   rf_raddr1    ALU in1 source register (rs)
//   rf_raddr2    ALU in2 source register (rt, or rs for MV)
//   rf_waddr     destination register (rd)
//   rf_we        register write enable (data = ALU out)
//   alu_op       ALU opcode (ADD_OP / MV_OP)
//   alu_src_imm  ALU in2 taken from imm_val instead of rf rdata2
//   imm_val      zero-extended ir[7:0]
//   c_flag       ALU registered carry flag
//   z_flag       ALU registered zero flag
//   halted       core stopped on HLT
//   illegal      sticky: undefined opcode executed
module toycpu_ctrl #(
  parameter int          PC_W   = 8,
  parameter int          RF_AW  = 4,
  parameter logic [3:0]  ADD_OP = 4'h1,
  parameter logic [3:0]  MV_OP  = 4'h2
) (
  input  logic             clk,
  input  logic             rst,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_ack,
  input  logic [15:0]      imem_rdata,
  output logic [RF_AW-1:0] rf_raddr1,
  output logic [RF_AW-1:0] rf_raddr2,
  output logic [RF_AW-1:0] rf_waddr,
  output logic             rf_we,
  output logic [3:0]       alu_op,
  output logic             alu_src_imm,
  output logic [15:0]      imm_val,
  input  logic             c_flag,
  input  logic             z_flag,
  output logic             halted,
  output logic             illegal
);

  typedef enum logic [1:0] {
    S_FETCH  = 2'd0,
    S_DECODE = 2'd1,
    S_EXEC   = 2'd2,
    S_HALT   = 2'd3
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_ADD = 4'h1,
    OP_MV  = 4'h2,
    OP_LDI = 4'h3,
    OP_JZ  = 4'h4,
    OP_JC  = 4'h5,
    OP_JMP = 4'h6,
    OP_HLT = 4'hF
  } opcode_e;

  state_e          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [15:0]     ir_q, ir_d;
  logic            illegal_q, illegal_d;

  logic [3:0]      opcode;
  logic [PC_W-1:0] jump_target;

  assign opcode      = ir_q[15:12];
  assign jump_target = ir_q[PC_W-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_FETCH;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state, PC and instruction-register update.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;

    unique case (state_q)
      S_FETCH: begin
        if (imem_ack) begin
          ir_d    = imem_rdata;
          pc_d    = pc_q + PC_W'(1);
          state_d = S_DECODE;
        end
      end

      S_DECODE: begin
        state_d = S_EXEC;
      end

      S_EXEC: begin
        state_d = S_FETCH;
        case (opcode)
          OP_NOP, OP_ADD, OP_MV, OP_LDI: ;
          OP_JMP: pc_d = jump_target;
          OP_JZ:  if (z_flag) pc_d = jump_target;
          OP_JC:  if (c_flag) pc_d = jump_target;
          OP_HLT: state_d = S_HALT;
          default: illegal_d = 1'b1;
        endcase
      end

      S_HALT: begin
        state_d = S_HALT;
      end

      default: begin
        state_d = S_FETCH;
      end
    endcase
  end

  // Outputs. Operand fields are presented from DECODE through EXEC so the
  // register file read data is settled before the EXEC write edge.
  always_comb begin
    imem_req    = 1'b0;
    imem_addr   = pc_q;
    rf_raddr1   = '0;
    rf_raddr2   = '0;
    rf_waddr    = '0;
    rf_we       = 1'b0;
    alu_op      = MV_OP;
    alu_src_imm = 1'b0;
    imm_val     = '0;
    halted      = 1'b0;
    illegal     = illegal_q;

    // The request is qualified with rst so it drops the moment reset is
    // asserted rather than waiting for the state register to settle.
    if (state_q == S_FETCH) begin
      imem_req = rst;
    end

    if ((state_q == S_DECODE) || (state_q == S_EXEC)) begin
      rf_waddr    = RF_AW'(ir_q[11:8]);
      rf_raddr1   = RF_AW'(ir_q[7:4]);
      // MV copies rs through the ALU's in2 path.
      rf_raddr2   = (opcode == OP_MV) ? RF_AW'(ir_q[7:4]) : RF_AW'(ir_q[3:0]);
      alu_src_imm = (opcode == OP_LDI);
      imm_val     = {8'h00, ir_q[7:0]};
    end

    if (state_q == S_EXEC) begin
      case (opcode)
        OP_ADD: begin
          alu_op = ADD_OP;
          rf_we  = 1'b1;
        end
        OP_MV, OP_LDI: begin
          rf_we = 1'b1;
        end
        default: ;
      endcase
    end

    if (state_q == S_HALT) begin
      halted = 1'b1;
    end
  end

endmodule

// File: tb/tb_toycpu_ctrl.sv
module tb_toycpu_ctrl;

  localparam int         PC_W   = 8;
  localparam int         RF_AW  = 4;
  localparam logic [3:0] ADD_OP = 4'h1;
  localparam logic [3:0] MV_OP  = 4'h2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             imem_req;
  logic [PC_W-1:0]  imem_addr;
  logic             imem_ack;
  logic [15:0]      imem_rdata;
  logic [RF_AW-1:0] rf_raddr1, rf_raddr2, rf_waddr;
  logic             rf_we;
  logic [3:0]       alu_op;
  logic             alu_src_imm;
  logic [15:0]      imm_val;
  logic             c_flag, z_flag;
  logic             halted, illegal;

  always #5 clk = ~clk;

  toycpu_ctrl #(.PC_W(PC_W), .RF_AW(RF_AW), .ADD_OP(ADD_OP), .MV_OP(MV_OP)) dut (
    .clk(clk), .rst(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .rf_raddr1(rf_raddr1), .rf_raddr2(rf_raddr2), .rf_waddr(rf_waddr), .rf_we(rf_we),
    .alu_op(alu_op), .alu_src_imm(alu_src_imm), .imm_val(imm_val),
    .c_flag(c_flag), .z_flag(z_flag), .halted(halted), .illegal(illegal)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name, input logic [63:0] act);
    checks++;
    failures++;
    $display("FAIL %s: got %0h expected no such event", name, act);
  endtask

  // Environment: program memory, register file / ALU flag model.
  logic [15:0] prog [256];
  logic [15:0] rf_m [16];
  logic        c_m = 1'b0, z_m = 1'b0;
  logic        force_z = 1'b0;
  int          clr_req = 0;
  int          clr_done = 0;

  assign c_flag = c_m;
  assign z_flag = force_z | z_m;

  // Scoreboard queues filled by the ISA-level reference model.
  typedef struct packed {
    logic        add;
    logic        imm;
    logic [3:0]  rd;
    logic [15:0] data;
  } wr_t;

  logic [PC_W-1:0] exp_fetch[$];
  wr_t             exp_wr[$];
  bit              exp_halt, exp_ill;

  // Instruction-level interpreter: runs the program from PC 0 and records
  // every fetch address and register write the core must produce.
  task automatic ref_build(input int n_max);
    logic [15:0] r [16];
    logic        c, z;
    logic [7:0]  pc;
    logic [15:0] ir, val;
    logic [16:0] s;
    for (int i = 0; i < 16; i++) r[i] = 16'h0000;
    c = 1'b0; z = 1'b0; pc = 8'h00;
    exp_halt = 1'b0; exp_ill = 1'b0;
    exp_fetch.delete();
    exp_wr.delete();
    for (int n = 0; n < n_max; n++) begin
      exp_fetch.push_back(pc);
      ir = prog[pc];
      pc = pc + 8'd1;
      case (ir[15:12])
        4'h0: ;
        4'h1: begin
          s = {1'b0, r[ir[7:4]]} + {1'b0, r[ir[3:0]]};
          exp_wr.push_back(wr_t'{add: 1'b1, imm: 1'b0, rd: ir[11:8], data: s[15:0]});
          r[ir[11:8]] = s[15:0];
          c = s[16];
          z = (s[15:0] == 16'h0000);
        end
        4'h2: begin
          val = r[ir[7:4]];
          exp_wr.push_back(wr_t'{add: 1'b0, imm: 1'b0, rd: ir[11:8], data: val});
          r[ir[11:8]] = val;
        end
        4'h3: begin
          val = {8'h00, ir[7:0]};
          exp_wr.push_back(wr_t'{add: 1'b0, imm: 1'b1, rd: ir[11:8], data: val});
          r[ir[11:8]] = val;
        end
        4'h4: if (z || force_z) pc = ir[7:0];
        4'h5: if (c) pc = ir[7:0];
        4'h6: pc = ir[7:0];
        4'hF: begin
          exp_halt = 1'b1;
          break;
        end
        default: exp_ill = 1'b1;
      endcase
    end
  endtask

  // Instruction memory responder with configurable ack latency; optional
  // stray acks while no request is outstanding.
  int delay_min = 0, delay_max = 0;
  bit noise = 1'b0;
  int cnt = -1;

  initial begin
    imem_ack = 1'b0;
    imem_rdata = 16'h0000;
    forever begin
      @(posedge clk or posedge rst_n);
      #1;
      if (!imem_req) begin
        cnt = -1;
        if (noise && ($urandom_range(3, 0) == 0)) begin
          imem_ack = 1'b1;
          imem_rdata = 16'($urandom);
        end else begin
          imem_ack = 1'b0;
        end
      end else begin
        if (cnt < 0) cnt = int'($urandom_range(delay_max, delay_min));
        if (cnt == 0) begin
          imem_ack = 1'b1;
          imem_rdata = prog[imem_addr];
        end else begin
          imem_ack = 1'b0;
          cnt--;
        end
      end
    end
  end

  // Monitor: models the register file / ALU and compares every fetch and
  // write the core presents against the scoreboard.
  bit              mon_en = 1'b0;
  int              cyc = 0;
  int              last_ack = -100;
  bit              have_ack = 1'b0;
  logic            prev_req = 1'b0, prev_ack = 1'b0;
  logic [PC_W-1:0] prev_addr = '0;

  always @(negedge clk) begin
    logic [15:0] in1, in2, out;
    logic [16:0] sum;
    wr_t         w;
    cyc++;
    if (clr_done != clr_req) begin
      for (int i = 0; i < 16; i++) rf_m[i] = 16'h0000;
      c_m = 1'b0;
      z_m = 1'b0;
      clr_done = clr_req;
    end
    in1 = rf_m[rf_raddr1];
    in2 = alu_src_imm ? imm_val : rf_m[rf_raddr2];
    sum = {1'b0, in1} + {1'b0, in2};
    out = (alu_op == ADD_OP) ? sum[15:0] : in2;
    if (!mon_en) have_ack = 1'b0;
    if (mon_en) begin
      if (prev_req && !prev_ack)
        chk("req_hold", {imem_req, imem_addr}, {1'b1, prev_addr});
      if (imem_req && !prev_req && have_ack)
        chk("fetch_gap", 64'(cyc - last_ack), 64'd3);
      if (imem_req && imem_ack) begin
        if (exp_fetch.size() == 0) fail_now("unexpected_fetch", imem_addr);
        else chk("fetch_addr", imem_addr, exp_fetch.pop_front());
        last_ack = cyc;
        have_ack = 1'b1;
      end
      if (rf_we) begin
        chk("we_slot", 64'(cyc - last_ack), 64'd2);
        if (exp_wr.size() == 0) fail_now("unexpected_write", {rf_waddr, out});
        else begin
          w = exp_wr.pop_front();
          chk("write", {alu_op == ADD_OP, alu_src_imm, rf_waddr, out, imem_req},
                       {w.add, w.imm, w.rd, w.data, 1'b0});
        end
      end
      if ((alu_op != MV_OP) && !((alu_op == ADD_OP) && rf_we))
        fail_now("alu_op_idle", alu_op);
    end
    if (rf_we) rf_m[rf_waddr] = out;
    if (alu_op == ADD_OP) begin
      c_m = sum[16];
      z_m = (sum[15:0] == 16'h0000);
    end
    prev_req = imem_req;
    prev_ack = imem_ack;
    prev_addr = imem_addr;
  end

  task automatic check_reset_vals(input string name);
    chk(name, {imem_req, imem_addr, rf_raddr1, rf_raddr2, rf_waddr, rf_we, alu_op,
               alu_src_imm, imm_val, halted, illegal},
              {1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 1'b0, MV_OP, 1'b0, 16'h0000, 1'b0, 1'b0});
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 256; i++) prog[i] = 16'h0000;
  endtask

  // Release reset, let the program run until every expected event has been
  // seen, check the halt behaviour, then put the core back into reset.
  task automatic run_program(input string name, input int n_max);
    int t;
    int bad;
    clr_req++;
    ref_build(n_max);
    @(posedge clk);
    #2;
    mon_en = 1'b1;
    rst_n = 1'b1;
    t = 0;
    while (((exp_fetch.size() != 0) || (exp_wr.size() != 0)) && (t < 3000)) begin
      @(posedge clk);
      t++;
    end
    if (t >= 3000) fail_now({name, "_timeout"}, 64'(exp_fetch.size()));
    if (exp_halt) begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk({name, "_halted"}, {halted, illegal}, {1'b1, exp_ill});
      bad = 0;
      repeat (20) begin
        @(negedge clk);
        if (imem_req || rf_we || !halted) bad++;
      end
      chk({name, "_halt_quiet"}, 64'(bad), 64'd0);
    end
    mon_en = 1'b0;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_vals({name, "_reset"});
    repeat (2) @(posedge clk);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    repeat (3) @(posedge clk);
    #2;
    check_reset_vals("por");

    // LDI with zero-wait memory.
    clear_prog();
    prog[0] = 16'h3105;
    prog[1] = 16'hF000;
    run_program("ldi", 10);

    // ADD then JZ: not taken with real flags, taken when z is forced.
    clear_prog();
    prog[0] = 16'h31FF;
    prog[1] = 16'h3201;
    prog[2] = 16'h1312;
    prog[3] = 16'h4010;
    prog[4] = 16'hF000;
    prog[16] = 16'hF000;
    run_program("jz_not", 20);
    force_z = 1'b1;
    run_program("jz_forced", 20);
    force_z = 1'b0;

    // Carry/zero from a 16-bit overflow drives JC then JZ, then an MV.
    clear_prog();
    prog[0] = 16'h3180;
    for (int i = 1; i <= 9; i++) prog[i] = 16'h1111;
    prog[10] = 16'h5020;
    prog[11] = 16'hF000;
    prog[32] = 16'h4030;
    prog[33] = 16'hF000;
    prog[48] = 16'h2410;
    prog[49] = 16'hF000;
    run_program("flags", 30);

    // Four wait cycles on every fetch.
    clear_prog();
    prog[0] = 16'h3105;
    prog[1] = 16'hF000;
    delay_min = 4;
    delay_max = 4;
    run_program("ack_wait", 10);
    delay_min = 0;
    delay_max = 0;

    // PC wrap from 0xFF to 0x00.
    clear_prog();
    prog[0] = 16'h60FF;
    prog[255] = 16'h0000;
    run_program("pc_wrap", 7);

    // Undefined opcode followed by HLT.
    clear_prog();
    prog[0] = 16'h7000;
    prog[1] = 16'hF000;
    run_program("illegal", 10);

    // Asynchronous reset while a fetch is waiting, then during an ADD EXEC.
    clear_prog();
    prog[0] = 16'h1312;
    prog[1] = 16'hF000;
    delay_min = 6;
    delay_max = 6;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #2;
    chk("fetch_waiting", {imem_req, imem_ack}, {1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_in_fetch");
    delay_min = 0;
    delay_max = 0;
    clr_req++;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (!(imem_req && imem_ack) && (t < 50));
    if (t >= 50) fail_now("exec_fetch_timeout", 64'(t));
    @(posedge clk);
    @(posedge clk);
    #2;
    chk("exec_reached", {rf_we, alu_op}, {1'b1, ADD_OP});
    rst_n = 1'b0;
    #1;
    check_reset_vals("rst_in_exec");
    repeat (2) @(posedge clk);
    run_program("after_reset", 10);

    // Random programs, random ack latency and stray acks.
    noise = 1'b1;
    delay_min = 0;
    delay_max = 3;
    for (int k = 0; k < 8; k++) begin
      for (int a = 0; a < 256; a++) begin
        int unsigned r;
        r = $urandom_range(15, 0);
        case (r)
          0, 1, 2, 15: prog[a] = {4'h1, 4'($urandom), 4'($urandom), 4'($urandom)};
          3, 4:        prog[a] = {4'h2, 4'($urandom), 4'($urandom), 4'h0};
          5, 6, 7:     prog[a] = {4'h3, 4'($urandom), 8'($urandom)};
          8:           prog[a] = {4'h4, 4'h0, 8'($urandom)};
          9:           prog[a] = {4'h5, 4'h0, 8'($urandom)};
          10:          prog[a] = {4'h6, 4'h0, 8'($urandom)};
          11:          prog[a] = 16'h0000;
          12:          prog[a] = {4'($urandom_range(14, 7)), 12'($urandom)};
          default:     prog[a] = 16'hF000;
        endcase
      end
      run_program("rand", 60);
    end
    noise = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
